// File: rtl/crossroad_controller.sv
// -----------------------------------------------------------------------------
// crossroad_controller
// Four-way crossroad traffic-light sequencer with a pedestrian walk phase.
// A free-running prescaler derives a one-second tick from clk_50MHz; a second
// counter times each phase in ticks. A pedestrian request latched at any time
// outside the walk phase is served after the next all-red clearance, after
// which the green that was due resumes.
//
// Optional feature: define TL_NIGHT_EN to add the 'night' input and the FLASH
// state (both lamps flashing yellow/off once per tick).
//
// Ports
//   clk_50MHz  in   sole clock, rising edge
//   res        in   synchronous active-low reset
//   ped_req    in   pedestrian button (level)
//   night      in   night-mode request (TL_NIGHT_EN only)
//   ns_light   out  [1:0] north-south lamp: 0 RED, 1 YELLOW, 2 GREEN, 3 OFF
//   ew_light   out  [1:0] east-west lamp, same encoding
//   walk       out  pedestrian walk lamp
//   ped_ack    out  one-clock pulse on entry to the walk phase
//   tick       out  one-clock pulse per second
//   phase      out  [2:0] current state code
// -----------------------------------------------------------------------------
module crossroad_controller #(
    parameter int CLK_DIV  = 50000000,
    parameter int T_GREEN  = 21,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2,
    parameter int T_WALK   = 10
) (
    input  logic       clk_50MHz,
    input  logic       res,
    input  logic       ped_req,
`ifdef TL_NIGHT_EN
    input  logic       night,
`endif
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic       ped_ack,
    output logic       tick,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ST_NS_GREEN  = 3'd0,
        ST_NS_YELLOW = 3'd1,
        ST_ALLRED_A  = 3'd2,
        ST_EW_GREEN  = 3'd3,
        ST_EW_YELLOW = 3'd4,
        ST_ALLRED_B  = 3'd5,
        ST_PED_WALK  = 3'd6
`ifdef TL_NIGHT_EN
        , ST_FLASH   = 3'd7
`endif
    } state_e;

    localparam logic [1:0] LAMP_RED    = 2'd0;
    localparam logic [1:0] LAMP_YELLOW = 2'd1;
    localparam logic [1:0] LAMP_GREEN  = 2'd2;
    localparam logic [1:0] LAMP_OFF    = 2'd3;

    localparam int PRE_W = $clog2(CLK_DIV);
    localparam int MAX_T0 = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
    localparam int MAX_T1 = (T_ALLRED > T_WALK) ? T_ALLRED : T_WALK;
    localparam int MAX_T2 = (MAX_T0 > MAX_T1) ? MAX_T0 : MAX_T1;
    // FLASH needs two counts even if every phase is one tick long
    localparam int MAX_T  = (MAX_T2 > 2) ? MAX_T2 : 2;
    localparam int SEC_W  = $clog2(MAX_T);

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1'b1);
    localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(1'b0);
    localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1'b1);
    localparam logic [SEC_W-1:0] SEC_ZERO = SEC_W'(1'b0);

    // Last sec_cnt value of each phase; FLASH (and any unused code) is two ticks.
    function automatic logic [SEC_W-1:0] len_m1(input state_e st);
        case (st)
            ST_NS_GREEN, ST_EW_GREEN:   len_m1 = SEC_W'(T_GREEN - 1);
            ST_NS_YELLOW, ST_EW_YELLOW: len_m1 = SEC_W'(T_YELLOW - 1);
            ST_ALLRED_A, ST_ALLRED_B:   len_m1 = SEC_W'(T_ALLRED - 1);
            ST_PED_WALK:                len_m1 = SEC_W'(T_WALK - 1);
            default:                    len_m1 = SEC_ONE;
        endcase
    endfunction

    // Lamp decode {ns, ew, walk}; anything unexpected shows all-red.
    function automatic logic [4:0] lamp_decode(input state_e st, input logic [SEC_W-1:0] sec);
        case (st)
            ST_NS_GREEN:  lamp_decode = {LAMP_GREEN,  LAMP_RED,    1'b0};
            ST_NS_YELLOW: lamp_decode = {LAMP_YELLOW, LAMP_RED,    1'b0};
            ST_EW_GREEN:  lamp_decode = {LAMP_RED,    LAMP_GREEN,  1'b0};
            ST_EW_YELLOW: lamp_decode = {LAMP_RED,    LAMP_YELLOW, 1'b0};
            ST_PED_WALK:  lamp_decode = {LAMP_RED,    LAMP_RED,    1'b1};
`ifdef TL_NIGHT_EN
            ST_FLASH:     lamp_decode = sec[0] ? {LAMP_OFF, LAMP_OFF, 1'b0}
                                               : {LAMP_YELLOW, LAMP_YELLOW, 1'b0};
`endif
            default:      lamp_decode = {LAMP_RED,    LAMP_RED,    1'b0};
        endcase
    endfunction

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    state_e           state_q, state_d, nxt_s;
    logic             pend_q, pend_d;
    logic             dir_ew_q, dir_ew_d;   // 1: walk phase returns to EW_GREEN
    logic             tick_s, expire_s, pend_eff_s, ack_d;
    logic [4:0]       lamp_d;

    // Next-state, counters, pending-request latch and decoded next outputs.
    always_comb begin
        presc_d    = presc_q;
        sec_d      = sec_q;
        nxt_s      = state_q;
        state_d    = state_q;
        pend_d     = pend_q;
        dir_ew_d   = dir_ew_q;
        tick_s     = (presc_q == PRE_MAX);
        expire_s   = tick_s && (sec_q == len_m1(state_q));
        // a request arriving in the expiry cycle itself is served immediately
        pend_eff_s = pend_q | ped_req;

        if (tick_s) begin
            presc_d = PRE_ZERO;
        end else begin
            presc_d = presc_q + PRE_ONE;
        end

        if (expire_s) begin
            sec_d = SEC_ZERO;
        end else if (tick_s) begin
            sec_d = sec_q + SEC_ONE;
        end else begin
            sec_d = sec_q;
        end

        if (expire_s) begin
            case (state_q)
                ST_NS_GREEN:  nxt_s = ST_NS_YELLOW;
                ST_NS_YELLOW: nxt_s = ST_ALLRED_A;
                ST_ALLRED_A: begin
                    dir_ew_d = 1'b1;
                    nxt_s    = pend_eff_s ? ST_PED_WALK : ST_EW_GREEN;
                end
                ST_EW_GREEN:  nxt_s = ST_EW_YELLOW;
                ST_EW_YELLOW: nxt_s = ST_ALLRED_B;
                ST_ALLRED_B: begin
                    dir_ew_d = 1'b0;
                    nxt_s    = pend_eff_s ? ST_PED_WALK : ST_NS_GREEN;
                end
                ST_PED_WALK:  nxt_s = dir_ew_q ? ST_EW_GREEN : ST_NS_GREEN;
                default:      nxt_s = ST_ALLRED_B;
            endcase
        end else begin
            nxt_s = state_q;
        end

`ifdef TL_NIGHT_EN
        // night overrides every other successor choice at expiry
        state_d = (expire_s && night) ? ST_FLASH : nxt_s;
`else
        state_d = nxt_s;
`endif

        if (state_q == ST_PED_WALK) begin
            pend_d = pend_q;
        end else if (state_d == ST_PED_WALK) begin
            pend_d = 1'b0;
        end else if (ped_req) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        ack_d  = (state_d == ST_PED_WALK) && (state_q != ST_PED_WALK);
        lamp_d = lamp_decode(state_d, sec_d);
    end

    // Core state registers.
    always_ff @(posedge clk_50MHz) begin
        if (!res) begin
            presc_q  <= PRE_ZERO;
            sec_q    <= SEC_ZERO;
            state_q  <= ST_ALLRED_B;
            pend_q   <= 1'b0;
            dir_ew_q <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            sec_q    <= sec_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
            dir_ew_q <= dir_ew_d;
        end
    end

    // Output registers, loaded from next-state values so they align with the state.
    always_ff @(posedge clk_50MHz) begin
        if (!res) begin
            ns_light <= LAMP_RED;
            ew_light <= LAMP_RED;
            walk     <= 1'b0;
            ped_ack  <= 1'b0;
            tick     <= 1'b0;
            phase    <= ST_ALLRED_B;
        end else begin
            ns_light <= lamp_d[4:3];
            ew_light <= lamp_d[2:1];
            walk     <= lamp_d[0];
            ped_ack  <= ack_d;
            tick     <= (presc_d == PRE_MAX);
            phase    <= state_d;
        end
    end

endmodule

// File: tb/tb_crossroad_controller.sv
module tb_crossroad_controller;

    localparam int CLK_DIV  = 4;
    localparam int T_GREEN  = 3;
    localparam int T_YELLOW = 2;
    localparam int T_ALLRED = 1;
    localparam int T_WALK   = 2;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       ped_req = 1'b0;
    logic       night = 1'b0;
    logic [1:0] ns_light, ew_light;
    logic       walk, ped_ack, tick;
    logic [2:0] phase;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    int seq[13] = '{5, 0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5};

    crossroad_controller #(
        .CLK_DIV(CLK_DIV), .T_GREEN(T_GREEN), .T_YELLOW(T_YELLOW),
        .T_ALLRED(T_ALLRED), .T_WALK(T_WALK)
    ) dut (
        .clk_50MHz(clk),
        .res(res),
        .ped_req(ped_req),
`ifdef TL_NIGHT_EN
        .night(night),
`endif
        .ns_light(ns_light),
        .ew_light(ew_light),
        .walk(walk),
        .ped_ack(ped_ack),
        .tick(tick),
        .phase(phase)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Tracks ticks remaining in the current phase rather than an up-counter.
    int m_presc = 0, m_phase = 5, m_left = T_ALLRED, m_after = 0, m_old = 0, m_nxt = 0;
    bit m_pend = 1'b0, m_ack = 1'b0, m_tk = 1'b0;

    function automatic int dur(input int p);
        case (p)
            0, 3:    dur = T_GREEN;
            1, 4:    dur = T_YELLOW;
            2, 5:    dur = T_ALLRED;
            6:       dur = T_WALK;
            default: dur = 2;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!res) begin
            m_presc = 0; m_phase = 5; m_left = T_ALLRED;
            m_pend = 1'b0; m_after = 0; m_ack = 1'b0;
        end else begin
            m_tk    = (m_presc == CLK_DIV - 1);
            m_old   = m_phase;
            m_presc = (m_presc + 1) % CLK_DIV;
            m_ack   = 1'b0;
            if (m_tk) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    case (m_old)
                        0: m_nxt = 1;
                        1: m_nxt = 2;
                        2: begin m_after = 3; m_nxt = (m_pend || ped_req) ? 6 : 3; end
                        3: m_nxt = 4;
                        4: m_nxt = 5;
                        5: begin m_after = 0; m_nxt = (m_pend || ped_req) ? 6 : 0; end
                        6: m_nxt = m_after;
                        default: m_nxt = 5;
                    endcase
                    if (night) m_nxt = 7;
                    m_phase = m_nxt;
                    m_left  = dur(m_nxt);
                    m_ack   = (m_nxt == 6);
                end
            end
            if (m_old != 6) begin
                if (m_phase == 6) m_pend = 1'b0;
                else if (ped_req) m_pend = 1'b1;
            end
        end
    end

    function automatic logic [9:0] exp_vec();
        logic [1:0] n, e;
        case (m_phase)
            0: begin n = 2'd2; e = 2'd0; end
            1: begin n = 2'd1; e = 2'd0; end
            3: begin n = 2'd0; e = 2'd2; end
            4: begin n = 2'd0; e = 2'd1; end
            7: begin n = (m_left == 2) ? 2'd1 : 2'd3; e = n; end
            default: begin n = 2'd0; e = 2'd0; end
        endcase
        exp_vec = {n, e, (m_phase == 6), m_ack, (m_presc == CLK_DIV - 1), 3'(m_phase)};
    endfunction

    // Every cycle: full output vector against the model, plus the conflict rule.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ({ns_light, ew_light, walk, ped_ack, tick, phase} !== exp_vec()) begin
                errors++;
                $display("FAIL monitor t=%0t got=%b expected=%b", $time,
                         {ns_light, ew_light, walk, ped_ack, tick, phase}, exp_vec());
            end
            checks++;
            if (phase != 3'd7 && ns_light != 2'd0 && ew_light != 2'd0) begin
                errors++;
                $display("FAIL conflict t=%0t ns=%0d ew=%0d expected one RED", $time, ns_light, ew_light);
            end
        end
    end

    task automatic do_reset();
        res = 1'b0;
        repeat (2) @(negedge clk);
        res = 1'b1;
    endtask

    task automatic test_reset();
        res = 1'b0;
        ped_req = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        checks++;
        if ({ns_light, ew_light, walk, ped_ack, tick, phase} !== 10'b00_00_0_0_0_101) begin
            errors++;
            $display("FAIL reset_state got=%b expected=%b",
                     {ns_light, ew_light, walk, ped_ack, tick, phase}, 10'b00_00_0_0_0_101);
        end
        res = 1'b1;
    endtask

    task automatic test_sequence();
        int idx = 0;
        int n = 0;
        while (idx < 13 && n < 200) begin
            @(negedge clk);
            n++;
            if (m_presc == CLK_DIV - 1) begin
                checks++;
                if (phase !== 3'(seq[idx]) || tick !== 1'b1) begin
                    errors++;
                    $display("FAIL sequence tick%0d phase=%0d tick=%b expected phase=%0d tick=1",
                             idx, phase, tick, seq[idx]);
                end
                idx++;
            end
        end
        checks++;
        if (idx != 13) begin
            errors++;
            $display("FAIL sequence_timeout ticks=%0d expected 13", idx);
        end
    endtask

    task automatic test_ped_pulse();
        int n = 0, acks = 0, walks = 0, ars = 0;
        logic [2:0] prev;
        do_reset();
        while (m_phase != 0 && n < 100) begin @(negedge clk); n++; end
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        prev = phase;
        n = 0;
        while (!(phase == 3'd3 && prev == 3'd6) && n < 200) begin
            prev = phase;
            @(negedge clk);
            n++;
            if (ped_ack === 1'b1) acks++;
            if (walk === 1'b1) walks++;
            if (phase === 3'd2) ars++;
        end
        checks++;
        if (acks != 1 || walks != 8 || ars != 4 || phase !== 3'd3) begin
            errors++;
            $display("FAIL ped_pulse acks=%0d walk_clks=%0d allred_clks=%0d end_phase=%0d expected 1/8/4/3",
                     acks, walks, ars, phase);
        end
    endtask

    task automatic test_ped_hold();
        int n = 0, acks = 0;
        logic [2:0] prev;
        do_reset();
        while (m_phase != 0 && n < 100) begin @(negedge clk); n++; end
        ped_req = 1'b1;
        n = 0;
        while (m_phase != 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (ped_ack === 1'b1) acks++;
        end
        @(negedge clk);
        ped_req = 1'b0;
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL hold_single_ack acks=%0d expected 1", acks);
        end
        n = 0;
        prev = phase;
        while (phase != 3'd6 && n < 200) begin
            prev = phase;
            @(negedge clk);
            n++;
        end
        checks++;
        if (phase !== 3'd6 || prev !== 3'd5 || ped_ack !== 1'b1) begin
            errors++;
            $display("FAIL hold_reserve phase=%0d from=%0d ack=%b expected 6 from 5 ack=1",
                     phase, prev, ped_ack);
        end
    endtask

    task automatic test_reset_in_walk();
        int n = 0;
        do_reset();
        while (m_phase != 0 && n < 100) begin @(negedge clk); n++; end
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        n = 0;
        while (!(m_phase == 6 && m_left == 1) && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        res = 1'b1;
        checks++;
        if ({ns_light, ew_light, walk, ped_ack, tick, phase} !== 10'b00_00_0_0_0_101) begin
            errors++;
            $display("FAIL reset_in_walk got=%b expected=%b",
                     {ns_light, ew_light, walk, ped_ack, tick, phase}, 10'b00_00_0_0_0_101);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (tick !== (k == 3)) begin
                errors++;
                $display("FAIL prescaler_cleared clk%0d tick=%b expected %b", k, tick, (k == 3));
            end
        end
    endtask

`ifdef TL_NIGHT_EN
    task automatic test_night();
        int n = 0;
        logic [2:0] prev;
        bit seen5 = 1'b0;
        do_reset();
        while (m_phase != 3 && n < 200) begin @(negedge clk); n++; end
        night = 1'b1;
        prev = phase;
        n = 0;
        while (phase != 3'd7 && n < 200) begin prev = phase; @(negedge clk); n++; end
        checks++;
        if (phase !== 3'd7 || prev !== 3'd3 || ns_light !== 2'd1 || ew_light !== 2'd1) begin
            errors++;
            $display("FAIL flash_entry phase=%0d from=%0d ns=%0d ew=%0d expected 7 from 3 lamps 1",
                     phase, prev, ns_light, ew_light);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (ns_light !== 2'd3 || ew_light !== 2'd3 || walk !== 1'b0) begin
            errors++;
            $display("FAIL flash_odd ns=%0d ew=%0d walk=%b expected 3 3 0", ns_light, ew_light, walk);
        end
        night = 1'b0;
        n = 0;
        while (phase != 3'd0 && n < 200) begin
            @(negedge clk);
            n++;
            if (phase === 3'd5) seen5 = 1'b1;
        end
        checks++;
        if (phase !== 3'd0 || !seen5) begin
            errors++;
            $display("FAIL flash_exit phase=%0d via_allred_b=%b expected 0 via 1", phase, seen5);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ped_req = ($urandom_range(0, 11) == 0);
            res = ($urandom_range(0, 399) != 0);
`ifdef TL_NIGHT_EN
            if ($urandom_range(0, 79) == 0) night = ~night;
`endif
        end
        @(negedge clk);
        res = 1'b1;
        ped_req = 1'b0;
        night = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_ped_pulse();
        test_ped_hold();
        test_reset_in_walk();
`ifdef TL_NIGHT_EN
        test_night();
`endif
        test_random();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
